// File: rtl/uart_tx_fifo.sv
// Transmit staging FIFO between the 6502 bus and an ACIA-style UART wrapper; a drain FSM
// polls wrapper txbusy and writes queued bytes. Optional low-water irq: define UART_TX_FIFO_IRQ_EN.
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int GUARD     = 2,
    parameter int LOW_WATER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       u_cs,
    output logic       u_we,
    output logic [1:0] u_addr,
    output logic [7:0] u_din,
    input  logic [7:0] u_dout,
    output logic       irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] GUARD_LAST = (GUARD > 0) ? 8'(GUARD - 1) : 8'd0;
    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_WAITS,
        ST_CHECK,
        ST_WRITE,
        ST_GUARD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_enable;
    logic          busy_q;
    logic [7:0]    guard_cnt;
    logic          full;
    logic          empty;
    logic          wr_data_req;
    logic          wr_ctrl_req;
    logic          rd_req;
    logic          push;
    logic          pop;
    logic [3:0]    count_sat;
    logic [7:0]    status;
    logic          u_cs_next;
    logic          u_we_next;
    logic [1:0]    u_addr_next;
    logic [7:0]    u_din_next;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign wr_data_req = cs & we & ~addr;
    assign wr_ctrl_req = cs & we & addr;
    assign rd_req      = cs & ~we;
    // A push on a full FIFO is dropped even when the drain pops in the same cycle.
    assign push        = wr_data_req & ~full;
    assign pop         = (state == ST_WRITE) & ~empty;

    // NOTE: every variable written in always_comb gets a default first, so no latch can form.
    always_comb begin
        count_sat = 4'hF;
        if (int'(count) < 15) count_sat = 4'(count);
    end

    assign status = {overflow, irq_enable, full, empty, count_sat};

    // NOTE: FIFO storage is not reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            irq_enable <= 1'b0;
            dout       <= 8'h00;
        end else begin
            if (wr_data_req && full)             overflow <= 1'b1;
            else if (wr_ctrl_req && din[7])      overflow <= 1'b0;
            if (wr_ctrl_req)                     irq_enable <= din[0];
            if (rd_req)                          dout <= addr ? status : 8'h00;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!empty) state_next = ST_POLL;
            ST_POLL:  state_next = ST_WAITS;
            ST_WAITS: state_next = ST_CHECK;
            ST_CHECK: state_next = busy_q ? ST_POLL : ST_WRITE;
            ST_WRITE: state_next = (GUARD > 0) ? ST_GUARD : ST_IDLE;
            ST_GUARD: if (guard_cnt == GUARD_LAST) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // Bus outputs are registered against the next state so they line up with the state register.
        u_cs_next   = (state_next == ST_POLL) || (state_next == ST_WRITE);
        u_we_next   = (state_next == ST_WRITE);
        u_addr_next = (state_next == ST_WRITE) ? ADDR_DATA : ADDR_STATUS;
        u_din_next  = (state_next == ST_WRITE) ? mem[rd_ptr] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            guard_cnt <= 8'd0;
            u_cs      <= 1'b0;
            u_we      <= 1'b0;
            u_addr    <= 2'b00;
            u_din     <= 8'h00;
        end else begin
            state  <= state_next;
            u_cs   <= u_cs_next;
            u_we   <= u_we_next;
            u_addr <= u_addr_next;
            u_din  <= u_din_next;
            // The wrapper presents status one cycle after POLL, i.e. during WAITS.
            if (state == ST_WAITS) busy_q <= u_dout[0];
            if (state == ST_WRITE)      guard_cnt <= 8'd0;
            else if (state == ST_GUARD) guard_cnt <= guard_cnt + 8'd1;
        end
    end

    logic unused_u_dout;
    assign unused_u_dout = ^u_dout[7:1];

`ifdef UART_TX_FIFO_IRQ_EN
    logic drained_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drained_flag <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr_data_req)                               drained_flag <= 1'b0;
            else if (pop && count == CW'(LOW_WATER + 1))   drained_flag <= 1'b1;
            irq <= irq_enable && (count <= CW'(LOW_WATER)) && drained_flag;
        end
    end
`else
    localparam int unused_low_water = LOW_WATER;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural wrapper model with a txbusy timer,
// a byte scoreboard of accepted pushes, and protocol monitors on the wrapper port.
module tb_uart_tx_fifo;

    localparam int DEPTH     = 16;
    localparam int GUARD     = 2;
    localparam int LOW_WATER = 4;
`ifdef UART_TX_FIFO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       we;
    logic       addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       u_cs;
    logic       u_we;
    logic [1:0] u_addr;
    logic [7:0] u_din;
    logic [7:0] u_dout = 8'h00;
    logic       irq;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .GUARD(GUARD), .LOW_WATER(LOW_WATER)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
        .u_cs(u_cs), .u_we(u_we), .u_addr(u_addr), .u_din(u_din), .u_dout(u_dout), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wrapper model: txbusy is a manual hold or a per-byte transmit timer.
    logic hold_busy = 1'b0;
    int   busy_cnt  = 0;
    int   max_bt    = 8;
    logic txbusy;
    assign txbusy = hold_busy || (busy_cnt != 0);

    always @(posedge clk) u_dout <= (u_addr == 2'b01) ? {7'd0, txbusy} : 8'h00;

    logic [7:0] exp_q[$];
    int   cyc = 0, last_wr = 0, wr_seen = 0, polls = 0, cs_cycles = 0;
    int   viol_busy = 0, viol_gap = 0, viol_proto = 0, unexpected = 0;
    logic prev_cs = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b1) begin
            if (u_cs) cs_cycles++;
            if (u_cs && prev_cs) viol_proto++;
            if (u_we && !u_cs) viol_proto++;
            if (u_cs && !u_we) begin
                polls++;
                if (u_addr != 2'b01) viol_proto++;
            end
            if (u_cs && u_we) begin
                if (u_addr != 2'b00) viol_proto++;
                if (txbusy) viol_busy++;
                if (wr_seen > 0 && (cyc - last_wr) < GUARD + 3) viol_gap++;
                if (exp_q.size() == 0) unexpected++;
                else check("tx_byte", u_din, exp_q.pop_front());
                last_wr  = cyc;
                wr_seen++;
                busy_cnt = $urandom_range(0, max_bt);
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
        end
        prev_cs = u_cs;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        cpu_write(1'b0, d);
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        v = dout;
    endtask

    function automatic logic [7:0] exp_status(input bit ovf, input bit ie, input int cnt);
        logic [3:0] c;
        c = (cnt >= 15) ? 4'hF : 4'(cnt);
        return {ovf, ie, (cnt == DEPTH), (cnt == 0), c};
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (GUARD + 12) tick();
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_seen < target && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int wr0, p0, c0;

        rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 1'b0; din = 8'h00;
        #2 rst = 1'b0;
        #1 check("reset_outputs", {dout, u_cs, u_we, u_addr, u_din, irq}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        c0 = cs_cycles;
        repeat (100) tick();
        check("idle_no_u_cs", cs_cycles - c0, 0);
        cpu_read(1'b1, v);
        check("reset_status", v, exp_status(0, 0, 0));
        cpu_read(1'b0, v);
        check("data_read_zero", v, 8'h00);

        // Single byte to an idle wrapper.
        wr0 = wr_seen;
        push_byte(8'h41, 1);
        wait_writes(wr0 + 1, 6);
        check("single_write_latency", wr_seen - wr0, 1);
        wait_drain("single_drain", 200);
        cpu_read(1'b1, v);
        check("single_status", v, exp_status(0, 0, 0));

        // Stalled wrapper: only polls until released, then ordered writes.
        hold_busy = 1'b1;
        wr0 = wr_seen; p0 = polls;
        push_byte(8'h55, 1); push_byte(8'hAA, 1); push_byte(8'h0F, 1);
        repeat (500) tick();
        check("stall_no_write", wr_seen - wr0, 0);
        check("stall_polling", (polls - p0) > 10, 1);
        cpu_read(1'b1, v);
        check("stall_status", v, exp_status(0, 0, 3));
        hold_busy = 1'b0;
        wait_drain("stall_drain", 500);
        check("stall_write_count", wr_seen - wr0, 3);

        // Overflow: 17 pushes into a stalled 16-entry FIFO.
        hold_busy = 1'b1;
        wr0 = wr_seen;
        for (int i = 0; i < 17; i++) push_byte(8'($urandom), exp_q.size() < DEPTH);
        cpu_read(1'b1, v);
        check("overflow_status", v, exp_status(1, 0, DEPTH));
        cpu_write(1'b1, 8'h80);
        cpu_read(1'b1, v);
        check("overflow_cleared", v, exp_status(0, 0, DEPTH));
        hold_busy = 1'b0;
        wait_drain("overflow_drain", 3000);
        check("overflow_write_count", wr_seen - wr0, DEPTH);

        // Asynchronous reset in the middle of a WRITE cycle.
        hold_busy = 1'b1;
        push_byte(8'h11, 1); push_byte(8'h22, 1); push_byte(8'h33, 1);
        repeat (5) tick();
        hold_busy = 1'b0;
        begin
            int n = 0;
            tick();
            while (!(u_cs && u_we) && n < 40) begin
                tick();
                n++;
            end
            check("reset_hit_write", {u_cs, u_we}, 2'b11);
        end
        #1 rst = 1'b0;
        #1 check("async_reset_outputs", {dout, u_cs, u_we, u_addr, u_din, irq}, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        wr0 = wr_seen;
        repeat (50) tick();
        check("reset_flushed", wr_seen - wr0, 0);
        cpu_read(1'b1, v);
        check("reset_release_status", v, exp_status(0, 0, 0));

        // Randomized traffic with random wrapper byte times.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 5);
            max_bt = $urandom_range(0, 30);
            if (r < 3 && exp_q.size() < DEPTH - 1) push_byte(8'($urandom), 1);
            else if (r == 3) begin
                cpu_read(1'b0, v);
                check("rand_data_read", v, 8'h00);
            end else if (r == 4) begin
                cpu_read(1'b1, v);
                check("rand_status_flags", v[7:6], 2'b00);
            end else tick();
        end
        wait_drain("rand_drain", 5000);
        cpu_read(1'b1, v);
        check("rand_final_status", v, exp_status(0, 0, 0));

        // Low-water interrupt.
        max_bt = 3;
        cpu_write(1'b1, 8'h01);
        hold_busy = 1'b1;
        wr0 = wr_seen;
        for (int i = 0; i < 8; i++) push_byte(8'($urandom), 1);
        cpu_read(1'b1, v);
        check("irq_queued_status", v, exp_status(0, 1, 8));
        check("irq_low_while_full", irq, 1'b0);
        hold_busy = 1'b0;
        wait_writes(wr0 + 4, 400);
        check("irq_fourth_write", wr_seen - wr0, 4);
        tick();
        check("irq_not_yet", irq, 1'b0);
        tick();
        check("irq_rise", irq, IRQ_ON);
        wait_drain("irq_drain", 500);
        check("irq_held_empty", irq, IRQ_ON);
        hold_busy = 1'b1;
        push_byte(8'h5A, 1);
        check("irq_push_lag", irq, IRQ_ON);
        @(negedge clk);
        check("irq_push_clear", irq, 1'b0);
        hold_busy = 1'b0;
        wait_drain("irq_final_drain", 200);
        cpu_read(1'b1, v);
        check("irq_final_status", v, exp_status(0, 1, 0));

        check("proto_violations", viol_proto, 0);
        check("write_while_busy", viol_busy, 0);
        check("write_gap", viol_gap, 0);
        check("unexpected_writes", unexpected, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
